// File: rtl/decode_stage_if.sv
// Fetch, writeback and ID/EX bundle signals of the decode stage.
// The slave side is the decode stage; the master side is its pipeline environment.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            stall;
  logic            flush;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [2:0]      ex_alu_op;
  logic            ex_reg_write;
  logic            illegal_sticky;

  modport master (
    output if_pc, if_instr, stall, flush, wb_en, wb_rd, wb_data,
    input  ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data,
           ex_alu_op, ex_reg_write, illegal_sticky
  );

  modport slave (
    input  if_pc, if_instr, stall, flush, wb_en, wb_rd, wb_data,
    output ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data,
           ex_alu_op, ex_reg_write, illegal_sticky
  );
endinterface

// File: rtl/decode_stage.sv
// IF/ID + ID/EX pipeline stage for the RV32 R-type ALU subset with an internal register file.
// Writeback is applied regardless of stall/flush and bypassed into same-edge operand reads.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [2:0]      alu_op;
    logic            reg_write;
  } ex_t;

  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  ex_t             ex_q, ex_d;
  logic            illegal_q, illegal_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1, rs2, rd;
  logic            dec_legal;
  logic [2:0]      dec_op;
  logic            wb_hit;
  logic            issue;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign opcode = ifid_instr_q[6:0];
  assign rd     = ifid_instr_q[11:7];
  assign funct3 = ifid_instr_q[14:12];
  assign rs1    = ifid_instr_q[19:15];
  assign rs2    = ifid_instr_q[24:20];
  assign funct7 = ifid_instr_q[31:25];

  // Flush wins over stall.
  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    if (bus.flush) begin
      ifid_valid_d = 1'b0;
    end else if (!bus.stall) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = bus.if_pc;
      ifid_instr_d = bus.if_instr;
    end
  end

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = ALU_ADD;
    if (opcode == OPC_OP) begin
      case ({funct7, funct3})
        10'b0000000_000: begin dec_legal = 1'b1; dec_op = ALU_ADD; end
        10'b0100000_000: begin dec_legal = 1'b1; dec_op = ALU_SUB; end
        10'b0000000_111: begin dec_legal = 1'b1; dec_op = ALU_AND; end
        10'b0000000_110: begin dec_legal = 1'b1; dec_op = ALU_OR;  end
        10'b0000000_100: begin dec_legal = 1'b1; dec_op = ALU_XOR; end
        default:         begin dec_legal = 1'b0; dec_op = ALU_ADD; end
      endcase
    end
  end

  assign wb_hit = bus.wb_en && (bus.wb_rd != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wb_hit) regs_d[bus.wb_rd] = bus.wb_data;
  end

  // Reading the post-write view gives the same-edge writeback bypass for free.
  assign rs1_val = (rs1 == 5'd0) ? '0 : regs_d[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs_d[rs2];

  assign issue     = ifid_valid_q && !bus.stall && !bus.flush;
  assign illegal_d = illegal_q | (issue & ~dec_legal);

  always_comb begin
    ex_d = '0;
    if (issue && dec_legal) begin
      ex_d.valid     = 1'b1;
      ex_d.pc        = ifid_pc_q;
      ex_d.rs1       = rs1;
      ex_d.rs2       = rs2;
      ex_d.rd        = rd;
      ex_d.rs1_data  = rs1_val;
      ex_d.rs2_data  = rs2_val;
      ex_d.alu_op    = dec_op;
      ex_d.reg_write = (rd != 5'd0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      ex_q         <= '0;
      illegal_q    <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ex_q         <= ex_d;
      illegal_q    <= illegal_d;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign bus.ex_valid       = ex_q.valid;
  assign bus.ex_pc          = ex_q.pc;
  assign bus.ex_rs1         = ex_q.rs1;
  assign bus.ex_rs2         = ex_q.rs2;
  assign bus.ex_rd          = ex_q.rd;
  assign bus.ex_rs1_data    = ex_q.rs1_data;
  assign bus.ex_rs2_data    = ex_q.rs2_data;
  assign bus.ex_alu_op      = ex_q.alu_op;
  assign bus.ex_reg_write   = ex_q.reg_write;
  assign bus.illegal_sticky = illegal_q;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a transaction-level model queues each instruction it
// expects to issue; a negedge monitor pops and compares whatever the DUT presents.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) bus ();
  decode_stage #(.XLEN(32), .NREGS(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2;
    logic [2:0]  op;
    logic        rw;
  } exp_t;

  localparam logic [31:0] NOP = 32'h00000033;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [9:0]  keys [5];
  logic        m_valid;
  logic [31:0] m_pc, m_instr;
  logic [31:0] m_regs [32];
  logic        m_sticky;
  logic [31:0] pc_ctr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Legal instructions are looked up in a table of {funct7,funct3}; the index is the ALU op.
  function automatic logic ref_decode(input logic [31:0] w, output logic [2:0] op);
    op = 3'd0;
    if (w[6:0] != 7'b0110011) return 1'b0;
    for (int i = 0; i < 5; i++)
      if ({w[31:25], w[14:12]} == keys[i]) begin
        op = 3'(i);
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic logic [31:0] rtype(input int k, input logic [4:0] rd, rs1, rs2);
    logic [9:0] key;
    key = keys[k];
    return {key[9:3], rs2, rs1, key[2:0], rd, 7'b0110011};
  endfunction

  // Applies the rules for one upcoming clock edge using the inputs currently driven.
  task automatic model_edge();
    exp_t       e;
    logic [2:0] op;
    if (bus.wb_en && bus.wb_rd != 5'd0) m_regs[bus.wb_rd] = bus.wb_data;
    if (m_valid && !bus.stall && !bus.flush) begin
      if (ref_decode(m_instr, op)) begin
        e.pc  = m_pc;
        e.rs1 = m_instr[19:15];
        e.rs2 = m_instr[24:20];
        e.rd  = m_instr[11:7];
        e.d1  = (e.rs1 == 5'd0) ? 32'd0 : m_regs[e.rs1];
        e.d2  = (e.rs2 == 5'd0) ? 32'd0 : m_regs[e.rs2];
        e.op  = op;
        e.rw  = (e.rd != 5'd0);
        sb.push_back(e);
      end else begin
        m_sticky = 1'b1;
      end
    end
    if (bus.flush) m_valid = 1'b0;
    else if (!bus.stall) begin
      m_valid = 1'b1;
      m_pc    = bus.if_pc;
      m_instr = bus.if_instr;
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_pc     = '0;
    m_instr  = '0;
    m_sticky = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    sb.delete();
  endtask

  task automatic cycle(input logic [31:0] instr, input logic st = 1'b0, input logic fl = 1'b0,
                       input logic we = 1'b0, input logic [4:0] wrd = 5'd0,
                       input logic [31:0] wdata = 32'd0);
    bus.if_pc    = pc_ctr;
    bus.if_instr = instr;
    bus.stall    = st;
    bus.flush    = fl;
    bus.wb_en    = we;
    bus.wb_rd    = wrd;
    bus.wb_data  = wdata;
    pc_ctr       = pc_ctr + 32'd4;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      chk("illegal_sticky", 32'(bus.illegal_sticky), 32'(m_sticky));
      if (bus.ex_valid) begin
        chk("issue_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("ex_pc", bus.ex_pc, e.pc);
          chk("ex_rs1", 32'(bus.ex_rs1), 32'(e.rs1));
          chk("ex_rs2", 32'(bus.ex_rs2), 32'(e.rs2));
          chk("ex_rd", 32'(bus.ex_rd), 32'(e.rd));
          chk("ex_rs1_data", bus.ex_rs1_data, e.d1);
          chk("ex_rs2_data", bus.ex_rs2_data, e.d2);
          chk("ex_alu_op", 32'(bus.ex_alu_op), 32'(e.op));
          chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(e.rw));
        end
      end else begin
        chk("missing_issue", 32'(sb.size()), 32'd0);
        chk("bubble_zero", 32'(|{bus.ex_pc, bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_rs1_data,
                                 bus.ex_rs2_data, bus.ex_alu_op, bus.ex_reg_write}), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] instr;
    int          r;
    keys[0] = 10'b0000000_000;
    keys[1] = 10'b0100000_000;
    keys[2] = 10'b0000000_111;
    keys[3] = 10'b0000000_110;
    keys[4] = 10'b0000000_100;
    bus.if_pc = '0; bus.if_instr = '0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    pc_ctr = 32'h0000_1000;
    model_reset();

    #1 rst = 1'b0;
    #2;
    chk("reset_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("reset_sticky", 32'(bus.illegal_sticky), 32'd0);
    chk("reset_ex_data", bus.ex_rs1_data | bus.ex_rs2_data, 32'd0);
    chk("reset_ex_op_rw", 32'({bus.ex_alu_op, bus.ex_reg_write}), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;

    // ADD x3,x1,x2 after x1=5, x2=7
    cycle(NOP, 1'b0, 1'b0, 1'b1, 5'd1, 32'd5);
    cycle(NOP, 1'b0, 1'b0, 1'b1, 5'd2, 32'd7);
    cycle(32'h002081B3);
    cycle(NOP);
    chk("add_valid", 32'(bus.ex_valid), 32'd1);
    chk("add_op", 32'(bus.ex_alu_op), 32'd0);
    chk("add_rd", 32'(bus.ex_rd), 32'd3);
    chk("add_rs1_data", bus.ex_rs1_data, 32'd5);
    chk("add_rs2_data", bus.ex_rs2_data, 32'd7);
    chk("add_reg_write", 32'(bus.ex_reg_write), 32'd1);

    // SUB/AND/OR/XOR back to back
    cycle(rtype(1, 5'd4, 5'd2, 5'd3));
    for (int k = 2; k <= 5; k++) begin
      cycle((k < 5) ? rtype(k, 5'(k + 3), 5'd1, 5'd2) : NOP);
      chk("stream_op", 32'(bus.ex_alu_op), 32'(k - 1));
    end

    // Writeback bypass, then x0 write ignored
    cycle(rtype(0, 5'd5, 5'd3, 5'd2));
    cycle(NOP, 1'b0, 1'b0, 1'b1, 5'd2, 32'hDEADBEEF);
    chk("bypass_rs2", bus.ex_rs2_data, 32'hDEADBEEF);
    cycle(NOP, 1'b0, 1'b0, 1'b1, 5'd0, 32'd99);
    cycle(rtype(0, 5'd6, 5'd0, 5'd2));
    cycle(NOP);
    chk("x0_reads_zero", bus.ex_rs1_data, 32'd0);

    // Stall three cycles, then stall+flush drop
    cycle(rtype(0, 5'd7, 5'd1, 5'd2));
    repeat (3) begin
      cycle(NOP, 1'b1);
      chk("stall_bubble", 32'(bus.ex_valid), 32'd0);
    end
    cycle(NOP);
    chk("stall_release_issue", 32'(bus.ex_rd), 32'd7);
    cycle(rtype(1, 5'd8, 5'd1, 5'd2));
    cycle(NOP, 1'b1, 1'b1);
    cycle(NOP);
    chk("flush_dropped", 32'(bus.ex_valid), 32'd0);

    // Illegal ADDI
    cycle(32'h00000013);
    cycle(NOP);
    chk("illegal_bubble", 32'(bus.ex_valid), 32'd0);
    chk("illegal_set", 32'(bus.illegal_sticky), 32'd1);
    cycle(rtype(2, 5'd9, 5'd1, 5'd2));
    cycle(rtype(4, 5'd10, 5'd1, 5'd2));

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 75)
        instr = rtype($urandom_range(0, 4), 5'($urandom), 5'($urandom), 5'($urandom));
      else if (r < 88)
        instr = {7'($urandom_range(0, 1) << 5), 10'($urandom), 3'($urandom), 5'($urandom), 7'b0110011};
      else
        instr = $urandom;
      cycle(instr, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
            1'($urandom), 5'($urandom), $urandom);
    end

    // Asynchronous reset while an instruction sits in ID/EX
    cycle(rtype(0, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 1'b1, 5'd1, 32'h1234);
    cycle(NOP, 1'b0, 1'b0, 1'b1, 5'd2, 32'h5678);
    chk("pre_reset_valid", 32'(bus.ex_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("async_sticky", 32'(bus.illegal_sticky), 32'd0);
    chk("async_ex_data", bus.ex_rs1_data | bus.ex_rs2_data, 32'd0);
    chk("async_ex_rd", 32'(bus.ex_rd), 32'd0);
    model_reset();
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    rst = 1'b1;
    cycle(rtype(0, 5'd3, 5'd1, 5'd2));
    cycle(NOP);
    chk("post_reset_x1", bus.ex_rs1_data, 32'd0);
    chk("post_reset_x2", bus.ex_rs2_data, 32'd0);

    repeat (3) cycle(NOP);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second pipeline stage, directly downstream of instruction fetch.
- Registers the fetched PC/instruction in an IF/ID register, decodes the RV32 R-type subset (ADD, SUB, AND, OR, XOR) and reads operands from an internal 32x32 register file.
- Writeback port from the last stage updates that register file.
- Presents a registered ID/EX bundle to execute, with stall/flush control and illegal-instruction detection.

Parameters:
XLEN, 32, datapath and PC width
NREGS, 32, architectural registers; register index width is 5 bits

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset: asynchronous, active-low (asserted at 0)
if_pc  input  XLEN  PC of instruction presented by fetch
if_instr  input  32  instruction word from fetch
stall  input  1  hold IF/ID contents; insert bubble into ID/EX
flush  input  1  discard instruction in IF/ID (next edge)
wb_en  input  1  register file write enable
wb_rd  input  5  writeback destination index
wb_data  input  XLEN  writeback data
ex_valid  output  1  ID/EX bundle holds a real instruction
ex_pc  output  XLEN  PC of ID/EX instruction
ex_rs1, ex_rs2, ex_rd  output  5 each  register indices (used for forwarding downstream)
ex_rs1_data, ex_rs2_data  output  XLEN  operand values
ex_alu_op  output  3  0=ADD 1=SUB 2=AND 3=OR 4=XOR
ex_reg_write  output  1  instruction writes rd (0 if rd==0 or bubble)
illegal_sticky  output  1  set once any valid illegal instruction is decoded

Behaviour:
- Reset (rst==0, async): IF/ID valid=0, all ex_* outputs 0, illegal_sticky=0, all 32 registers cleared to 0. On release, the first rising edge captures if_instr into IF/ID with valid=1.
- IF/ID register, each edge:
  - flush=1: valid<=0, whatever stall is.
  - else stall=1: hold pc/instr/valid.
  - else: capture if_pc, if_instr, valid<=1.
- Decode (combinational from IF/ID):
  - Legal iff opcode==7'b0110011 and (f3,f7) ∈ {(000,0000000)=ADD, (000,0100000)=SUB, (111,0000000)=AND, (110,0000000)=OR, (100,0000000)=XOR}.
  - rs1=[19:15], rs2=[24:20], rd=[11:7].
- ID/EX register, each edge:
  - Bubble if stall=1, flush=1, IF/ID invalid, or instruction illegal.
  - Bubble: ex_valid=0, ex_reg_write=0, ex_alu_op=0; other fields don't-care but must hold 0.
  - Otherwise load the decoded fields, ex_valid=1, ex_reg_write=(rd!=0).
- Latency: instruction on if_instr before edge N appears on ex_* after edge N+1, absent stall/flush.
- Illegal: a valid, unflushed, unstalled IF/ID instruction that is illegal sets illegal_sticky on the same edge that would have loaded it. Cleared only by reset. The instruction becomes a bubble.
- Register file:
  - Write on edge when wb_en=1 and wb_rd!=0.
  - Writes to x0 ignored; reads of x0 always return 0.
- Same-cycle write/read bypass: if wb_en=1, wb_rd!=0 and wb_rd equals rs1 (rs2), ex_rs1_data (ex_rs2_data) captures wb_data, not the old array value.
- Writeback is independent of stall/flush; it occurs even while stalled.
- Stall held multiple cycles: IF/ID keeps the same instruction; ID/EX emits a bubble every cycle. Release reissues that instruction once.
- Hazard detection and forwarding between in-flight instructions are not done here. Downstream uses the ex_rs*/ex_rd indices.

Test Plan:
- Reset low then released; fetch ADD x3,x1,x2 (32'h002081B3) after wb writes x1=5, x2=7 → two edges later ex_valid=1, ex_alu_op=0, ex_rd=3, ex_rs1_data=5, ex_rs2_data=7, ex_reg_write=1.
- Stream SUB x4,x2,x3 / AND / OR / XOR back-to-back → ex_alu_op sequence 1,2,3,4 on consecutive cycles, ex_pc increments by 4.
- Bypass: wb_en=1, wb_rd=2, wb_data=32'hDEADBEEF in the same cycle IF/ID holds ADD x5,x3,x2 → ex_rs2_data=32'hDEADBEEF. Then wb to x0 with data 99 → a later read of x0 returns 0.
- Stall asserted 3 cycles with ADD in IF/ID → ex_valid=0 for 3 cycles, then ADD issued exactly once. Stall+flush together → instruction dropped, never reaches ex.
- Illegal: if_instr=32'h00000013 (ADDI) → ex_valid stays 0, illegal_sticky=1 and remains 1 across subsequent legal instructions.
- Assert rst low mid-stream while ex_valid=1 → ex_valid, illegal_sticky and all registers read 0 immediately, without waiting for a clock edge.
